// File: rtl/run_sequencer_if.sv
// Control-bus bundle between run_sequencer (master) and the datapath (slave).
interface run_sequencer_if;
    logic        run;
    logic [31:0] ir;
    logic        con_ff;
    logic [2:0]  gr_sel;
    logic [2:0]  rf_ctl;
    logic [2:0]  pc_ctl;
    logic [4:0]  mem_ctl;
    logic [4:0]  alu_ctl;
    logic [3:0]  hilo_ctl;
    logic [2:0]  io_ctl;
    logic [4:0]  alu_control;
    logic [3:0]  state;
    logic        halted;

    modport master (
        input  run, ir, con_ff,
        output gr_sel, rf_ctl, pc_ctl, mem_ctl, alu_ctl, hilo_ctl, io_ctl,
               alu_control, state, halted
    );

    modport slave (
        output run, ir, con_ff,
        input  gr_sel, rf_ctl, pc_ctl, mem_ctl, alu_ctl, hilo_ctl, io_ctl,
               alu_control, state, halted
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: hardwired control-step sequencer (fetch T0-T2, execute T3-T7, HALT).
// Optional feature macro MUL_DIV_EN adds mul/div/mfhi/mflo; without it they decode as nop.
module run_sequencer (
    input logic             clk,
    input logic             clr,
    run_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ROP, C_IMM, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MULDIV, C_MFHI, C_MFLO, C_HALT
    } op_class_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    state_t     state_q, state_n;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic [4:0] imm_alu;
    logic       unused_ir;
    logic       last;

    logic gra, grb, grc, rin, rout, baout, pout, pen, incpc;
    logic maren, mdren, mdrout, rd, wr;
    logic yen, zloen, zhien, zloout, cout;
    logic outport, inportout, conin;
    logic [4:0] alu_op;
`ifdef MUL_DIV_EN
    logic hien, loen, hiout, loout;
`endif

    assign opcode    = bus.ir[31:27];
    assign unused_ir = ^bus.ir[26:0];

    // Only the opcode field steers sequencing; register fields go straight to the datapath.
    always_comb begin
        op_class = C_NOP;
        case (opcode)
            5'b00000: op_class = C_LD;
            5'b00001: op_class = C_LDI;
            5'b00010: op_class = C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: op_class = C_ROP;
            5'b01011, 5'b01100, 5'b01101: op_class = C_IMM;
`ifdef MUL_DIV_EN
            5'b01110, 5'b01111: op_class = C_MULDIV;
            5'b10111: op_class = C_MFHI;
            5'b11000: op_class = C_MFLO;
`endif
            5'b10000, 5'b10001: op_class = C_UNARY;
            5'b10010: op_class = C_BR;
            5'b10011: op_class = C_JR;
            5'b10101: op_class = C_IN;
            5'b10110: op_class = C_OUT;
            5'b11010: op_class = C_HALT;
            default:  op_class = C_NOP;
        endcase
    end

    always_comb begin
        case (opcode)
            5'b01011: imm_alu = ALU_ADD;
            5'b01100: imm_alu = ALU_AND;
            default:  imm_alu = ALU_OR;
        endcase
    end

    // NOTE: every variable written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state_q;
        last    = 1'b0;
        {gra, grb, grc, rin, rout, baout, pout, pen, incpc} = '0;
        {maren, mdren, mdrout, rd, wr}                      = '0;
        {yen, zloen, zhien, zloout, cout}                   = '0;
        {outport, inportout, conin}                         = '0;
        alu_op = 5'b00000;
`ifdef MUL_DIV_EN
        {hien, loen, hiout, loout} = '0;
`endif
        case (state_q)
            S_IDLE: if (bus.run) state_n = S_T0;
            S_T0: begin
                pout = 1'b1; maren = 1'b1; incpc = 1'b1; pen = 1'b1;
                state_n = S_T1;
            end
            S_T1: begin
                rd = 1'b1; mdren = 1'b1;
                state_n = S_T2;
            end
            S_T2: begin
                // IR is loaded from MDR this step; the datapath derives its IR strobe from state.
                mdrout = 1'b1;
                case (op_class)
                    C_HALT:  state_n = S_HALT;
                    C_NOP:   last = 1'b1;
                    default: state_n = S_T3;
                endcase
            end
            S_T3: begin
                state_n = S_T4;
                case (op_class)
                    C_ROP, C_IMM: begin grb = 1'b1; rout = 1'b1; yen = 1'b1; end
                    C_UNARY: begin
                        grb = 1'b1; rout = 1'b1; zloen = 1'b1; alu_op = opcode;
                    end
                    C_LD, C_LDI, C_ST: begin grb = 1'b1; baout = 1'b1; yen = 1'b1; end
                    C_BR:  begin gra = 1'b1; rout = 1'b1; conin = 1'b1; end
                    C_JR:  begin gra = 1'b1; rout = 1'b1; pen = 1'b1; last = 1'b1; end
                    C_IN:  begin inportout = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
                    C_OUT: begin gra = 1'b1; rout = 1'b1; outport = 1'b1; last = 1'b1; end
`ifdef MUL_DIV_EN
                    C_MULDIV: begin gra = 1'b1; rout = 1'b1; yen = 1'b1; end
                    C_MFHI: begin hiout = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
                    C_MFLO: begin loout = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T4: begin
                state_n = S_T5;
                case (op_class)
                    C_ROP: begin grc = 1'b1; rout = 1'b1; zloen = 1'b1; alu_op = opcode; end
                    C_IMM: begin cout = 1'b1; zloen = 1'b1; alu_op = imm_alu; end
                    C_UNARY: begin zloout = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1; end
                    C_LD, C_LDI, C_ST: begin cout = 1'b1; zloen = 1'b1; alu_op = ALU_ADD; end
                    C_BR: begin pout = 1'b1; yen = 1'b1; end
`ifdef MUL_DIV_EN
                    C_MULDIV: begin
                        grb = 1'b1; rout = 1'b1; zloen = 1'b1; zhien = 1'b1; alu_op = opcode;
                    end
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T5: begin
                state_n = S_T6;
                case (op_class)
                    C_ROP, C_IMM, C_LDI: begin
                        zloout = 1'b1; gra = 1'b1; rin = 1'b1; last = 1'b1;
                    end
                    C_LD, C_ST: begin zloout = 1'b1; maren = 1'b1; end
                    C_BR: begin cout = 1'b1; zloen = 1'b1; alu_op = ALU_ADD; end
`ifdef MUL_DIV_EN
                    C_MULDIV: begin zloout = 1'b1; loen = 1'b1; end
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T6: begin
                state_n = S_T7;
                case (op_class)
                    C_LD: begin rd = 1'b1; mdren = 1'b1; end
                    C_ST: begin gra = 1'b1; rout = 1'b1; mdren = 1'b1; end
                    C_BR: begin zloout = 1'b1; pen = bus.con_ff; last = 1'b1; end
`ifdef MUL_DIV_EN
                    // No ZHIout pin exists; HIen alone captures the high half from Z.
                    C_MULDIV: begin hien = 1'b1; last = 1'b1; end
`endif
                    default: last = 1'b1;
                endcase
            end
            S_T7: begin
                last = 1'b1;
                case (op_class)
                    C_LD:    begin mdrout = 1'b1; gra = 1'b1; rin = 1'b1; end
                    C_ST:    wr = 1'b1;
                    default: ;
                endcase
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
        if (last) state_n = bus.run ? S_T0 : S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignment; clr clears it without waiting for clk.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= S_IDLE;
        else      state_q <= state_n;
    end

    assign bus.gr_sel      = {gra, grb, grc};
    assign bus.rf_ctl      = {rin, rout, baout};
    assign bus.pc_ctl      = {pout, pen, incpc};
    assign bus.mem_ctl     = {maren, mdren, mdrout, rd, wr};
    assign bus.alu_ctl     = {yen, zloen, zhien, zloout, cout};
    assign bus.io_ctl      = {outport, inportout, conin};
    assign bus.alu_control = alu_op;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == S_HALT);
`ifdef MUL_DIV_EN
    assign bus.hilo_ctl    = {hien, loen, hiout, loout};
`else
    assign bus.hilo_ctl    = 4'b0000;
`endif
endmodule
